// File: rtl/apsr_it_if.sv
// Signal bundle between the retire stage and the APSR/ITSTATE controller.
// The master drives retire-side controls; the slave returns flags and IT condition state.
interface apsr_it_if;
    logic       it_load;
    logic [3:0] it_firstcond;
    logic [3:0] it_mask;
    logic       instr_retire;
    logic       exec_passed;
    logic [3:0] flag_we;
    logic [3:0] flag_in;
    logic       msr_we;
    logic [3:0] msr_nzcv;
    logic       it_flush;
    logic [3:0] instr_cond;
    logic [3:0] cond;
    logic [3:0] apsr_reg_nzcv;
    logic [7:0] itstate;
    logic       in_it;
    logic       last_in_it;
    logic       it_err;

    modport master (
        output it_load, it_firstcond, it_mask, instr_retire, exec_passed, flag_we, flag_in,
               msr_we, msr_nzcv, it_flush, instr_cond,
        input  cond, apsr_reg_nzcv, itstate, in_it, last_in_it, it_err
    );

    modport slave (
        input  it_load, it_firstcond, it_mask, instr_retire, exec_passed, flag_we, flag_in,
               msr_we, msr_nzcv, it_flush, instr_cond,
        output cond, apsr_reg_nzcv, itstate, in_it, last_in_it, it_err
    );
endinterface

// File: rtl/apsr_it_ctrl.sv
// APSR NZCV flag register and Thumb ITSTATE sequencer.
// Supplies the active condition code and flags illegal or rejected IT loads.
module apsr_it_ctrl (
    input logic      clk,
    input logic      rst_n,
    apsr_it_if.slave bus
);

    logic [7:0] itstate_q, itstate_d;
    logic [3:0] nzcv_q, nzcv_d;
    logic       it_err_q, it_err_d;
    logic       in_it;
    logic       load_ok;

    always_comb begin
        in_it   = (itstate_q[3:0] != 4'b0000);
        load_ok = bus.it_load && !in_it && (bus.it_firstcond != 4'b1111)
                  && (bus.it_mask != 4'b0000);
    end

    always_comb begin
        itstate_d = itstate_q;
        if (bus.it_flush) begin
            itstate_d = 8'h00;
        end else if (bus.it_load) begin
            if (load_ok) begin
                itstate_d = {bus.it_firstcond, bus.it_mask};
            end
        end else if (bus.instr_retire && in_it) begin
            // Mask shifts left into cond[0]; the block ends once only the terminator bit remains.
            if (itstate_q[2:0] == 3'b000) begin
                itstate_d = 8'h00;
            end else begin
                itstate_d = {itstate_q[7:5], itstate_q[3:0], 1'b0};
            end
        end
    end

    always_comb begin
        it_err_d = bus.it_load && !load_ok;
    end

    always_comb begin
        nzcv_d = nzcv_q;
        if (bus.msr_we) begin
            nzcv_d = bus.msr_nzcv;
        end else if (bus.instr_retire && bus.exec_passed) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.flag_we[i]) begin
                    nzcv_d[i] = bus.flag_in[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            itstate_q <= 8'h00;
            nzcv_q    <= 4'b0000;
            it_err_q  <= 1'b0;
        end else begin
            itstate_q <= itstate_d;
            nzcv_q    <= nzcv_d;
            it_err_q  <= it_err_d;
        end
    end

    assign bus.itstate       = itstate_q;
    assign bus.apsr_reg_nzcv = nzcv_q;
    assign bus.it_err        = it_err_q;
    assign bus.in_it         = in_it;
    assign bus.last_in_it    = (itstate_q[3:0] == 4'b1000);
    assign bus.cond          = in_it ? itstate_q[7:4] : bus.instr_cond;

endmodule

// File: doc/apsr_it_ctrl.md
APSR_IT_CTRL -- requirements
Module: apsr_it_ctrl

Interface
REQ-001 clk  input  1  core clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 it_load  input  1  IT instruction retiring; load ITSTATE this cycle.
REQ-004 it_firstcond  input  4  IT firstcond field.
REQ-005 it_mask  input  4  IT mask field.
REQ-006 instr_retire  input  1  one non-IT instruction retires, whether executed or condition-skipped.
REQ-007 exec_passed  input  1  retiring instruction passed its condition check.
REQ-008 flag_we  input  4  per-flag write enable, bit order N,Z,C,V (bit3..bit0).
REQ-009 flag_in  input  4  new flag values from the ALU, same bit order.
REQ-010 msr_we  input  1  MSR APSR write.
REQ-011 msr_nzcv  input  4  MSR flag data.
REQ-012 it_flush  input  1  branch or exception; abandon any IT block.
REQ-013 instr_cond  input  4  condition of the instruction's own encoding, used outside IT blocks.
REQ-014 cond  output  4  condition presented to the condition evaluator.
REQ-015 apsr_reg_nzcv  output  4  registered flags {N,Z,C,V}.
REQ-016 itstate  output  8  registered ITSTATE.
REQ-017 in_it  output  1  current instruction is inside an IT block.
REQ-018 last_in_it  output  1  current instruction is the last one of the IT block.
REQ-019 it_err  output  1  registered one-cycle pulse flagging an illegal or rejected IT load.

Function
REQ-020 in_it SHALL equal (itstate[3:0] != 0) and is combinational from the register.
REQ-021 last_in_it SHALL equal (itstate[3:0] == 4'b1000).
REQ-022 cond SHALL equal itstate[7:4] when in_it=1; otherwise it SHALL equal instr_cond.
REQ-023 An accepted IT load SHALL write itstate = {it_firstcond, it_mask} on the next edge.
REQ-024 An IT load SHALL be accepted only when in_it=0, it_firstcond != 4'b1111 and it_mask != 4'b0000.
REQ-025 A rejected IT load SHALL leave itstate unchanged and set it_err=1 for exactly the next cycle.
REQ-026 When instr_retire=1 and in_it=1, advance ITSTATE:
  - if itstate[2:0]==3'b000, itstate becomes 8'h00;
  - otherwise itstate[7:5] holds and itstate[4:0] becomes {itstate[3:0],1'b0}.
  Latency is one cycle.
REQ-027 instr_retire with in_it=0 SHALL NOT change itstate.
REQ-028 Priority on itstate: it_flush (clears to 8'h00), then it_load, then instr_retire advance.
REQ-029 Simultaneous it_load and instr_retire with in_it=0: the load SHALL be applied and the retire ignored for ITSTATE.
REQ-030 Per flag i, apsr_reg_nzcv[i] SHALL update to flag_in[i] on the next edge when instr_retire & exec_passed & flag_we[i].
REQ-031 msr_we SHALL write all four flags from msr_nzcv and takes priority over ALU flag writes in the same cycle.
REQ-032 Flags with no write enable active SHALL hold; it_flush SHALL NOT affect the flags.
REQ-033 An instruction that fails its condition (exec_passed=0) SHALL still advance ITSTATE and SHALL NOT write any flag.

Reset
REQ-034 rst_n=0 sampled at an edge SHALL set itstate=8'h00, apsr_reg_nzcv=4'b0000 and it_err=0, so cond=instr_cond, in_it=0 and last_in_it=0.
REQ-035 Reset SHALL override every other input, including in the middle of an IT block.

Verification
REQ-036 ITTE EQ: it_load with firstcond=0000, mask=0110 -> itstate=06, cond=0000. Retire -> itstate=0C, cond=0000. Retire -> itstate=18, cond=0001, last_in_it=1. Retire -> itstate=00, cond=instr_cond.
REQ-037 Illegal loads: firstcond=1111 -> it_err pulses one cycle, itstate stays 00. Mask=0000 -> same result. A second load while in_it=1 -> it_err=1 and ITSTATE unchanged.
REQ-038 Flags: flag_we=1010, flag_in=1111, exec_passed=1, retire -> nzcv=1010 from 0000. Same inputs with exec_passed=0 -> nzcv unchanged.
REQ-039 Same cycle, msr_we=1 with msr_nzcv=0101 and an ALU write of 1111 with flag_we=1111 -> nzcv=0101.
REQ-040 it_flush mid-block with itstate=0C -> itstate=00 and flags unchanged. it_flush together with it_load -> itstate=00.
REQ-041 rst_n=0 during an IT block with nzcv=1111 -> next cycle itstate=00, nzcv=0000, it_err=0.
